// File: rtl/restoring_divider_datapath_if.sv
// Operator-side bundle for the restoring divider: push buttons and switches in,
// the dividend register, results, status flags and hex segment drives out.
interface restoring_divider_datapath_if #(
    parameter int WIDTH = 16
);
    // Load_B and Run are asynchronous active-low levels with no ready/ack.
    // A Run press produces one division. Done stays high until Run is released.
    // Results are held until the next completed start.
    logic             Load_B;
    logic             Run;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] reg_out;
    logic [WIDTH-1:0] Quotient_out;
    logic [WIDTH-1:0] Remainder_out;
    logic             Busy;
    logic             Done;
    logic             Div_zero;
    logic [6:0]       Ahex0, Ahex1, Ahex2, Ahex3;
    logic [6:0]       Bhex0, Bhex1, Bhex2, Bhex3;
    logic [1:0]       state_dbg;

    modport master (
        output Load_B, Run, SW,
        input  reg_out, Quotient_out, Remainder_out, Busy, Done, Div_zero,
        input  Ahex0, Ahex1, Ahex2, Ahex3, Bhex0, Bhex1, Bhex2, Bhex3, state_dbg
    );

    modport slave (
        input  Load_B, Run, SW,
        output reg_out, Quotient_out, Remainder_out, Busy, Done, Div_zero,
        output Ahex0, Ahex1, Ahex2, Ahex3, Bhex0, Bhex1, Bhex2, Bhex3, state_dbg
    );
endinterface

// File: rtl/restoring_divider_datapath.sv
// Sequential unsigned restoring divider. The quotient is written back into the
// dividend register, so repeated Run presses chain divisions.
module restoring_divider_datapath #(
    parameter int WIDTH = 16
) (
    input logic Clk,
    input logic Reset,
    restoring_divider_datapath_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic ld_s1_q, ld_s2_q, go_s1_q, go_s2_q;
    logic ld, go;

    logic [WIDTH-1:0] reg_q, reg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   t;
    logic             t_ge;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic             last_step;
    logic             busy, done;

    // Synchronizers reset to 1 so both buttons read as released.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ld_s1_q <= 1'b1;
            ld_s2_q <= 1'b1;
            go_s1_q <= 1'b1;
            go_s2_q <= 1'b1;
        end else begin
            ld_s1_q <= bus.Load_B;
            ld_s2_q <= ld_s1_q;
            go_s1_q <= bus.Run;
            go_s2_q <= go_s1_q;
        end
    end

    assign ld = ~ld_s2_q;
    assign go = ~go_s2_q;

    // One restoring step. When T >= divisor the difference fits in WIDTH bits,
    // so only the low WIDTH bits need to be subtracted.
    assign t         = {r_q, q_q[WIDTH-1]};
    assign t_ge      = (t >= {1'b0, div_q});
    assign r_step    = t_ge ? (t[WIDTH-1:0] - div_q) : t[WIDTH-1:0];
    assign q_step    = {q_q[WIDTH-2:0], t_ge};
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!ld && go) state_d = (bus.SW == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (last_step) state_d = S_DONE;
            end
            S_DONE: begin
                if (!go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_CALC:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        reg_d  = reg_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        div_d  = div_q;
        r_d    = r_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        dz_d   = dz_q;
        case (state_q)
            S_IDLE: begin
                if (ld) begin
                    reg_d = bus.SW;
                end else if (go) begin
                    div_d = bus.SW;
                    r_d   = '0;
                    q_d   = reg_q;
                    cnt_d = '0;
                    if (bus.SW == '0) begin
                        quot_d = '1;
                        rem_d  = reg_q;
                        dz_d   = 1'b1;
                    end
                end
            end
            S_CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CNT_W'(1);
                // Publish the final step directly so results appear with Done.
                if (last_step) begin
                    quot_d = q_step;
                    rem_d  = r_step;
                    reg_d  = q_step;
                    dz_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            reg_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            r_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            reg_q  <= reg_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            r_q    <= r_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            dz_q   <= dz_d;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign bus.reg_out       = reg_q;
    assign bus.Quotient_out  = quot_q;
    assign bus.Remainder_out = rem_q;
    assign bus.Busy          = busy;
    assign bus.Done          = done;
    assign bus.Div_zero      = dz_q;
    assign bus.state_dbg     = state_q;

    assign bus.Ahex0 = hex7(bus.SW[3:0]);
    assign bus.Ahex1 = hex7(bus.SW[7:4]);
    assign bus.Ahex2 = hex7(bus.SW[11:8]);
    assign bus.Ahex3 = hex7(bus.SW[15:12]);
    assign bus.Bhex0 = hex7(reg_q[3:0]);
    assign bus.Bhex1 = hex7(reg_q[7:4]);
    assign bus.Bhex2 = hex7(reg_q[11:8]);
    assign bus.Bhex3 = hex7(reg_q[15:12]);
endmodule

// File: doc/restoring_divider_datapath.md
Name: restoring_divider_datapath

Overview:
Sequential 16-bit unsigned restoring divider datapath for the exp4 board flow; the subtract/shift counterpart of the CLA accumulate datapath. Operator loads a dividend from SW with Load_B, then presses Run to divide the stored value by the divisor on SW. The quotient is written back into the dividend register, so repeated Run presses chain divisions. Hex displays show SW (divisor) and the dividend register.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits.

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Load_B  input  1  active-low push button: load dividend register from SW
Run  input  1  active-low push button: start one division
SW  input  WIDTH  switches: dividend on load, divisor on start
reg_out  output  WIDTH  dividend register contents
Quotient_out  output  WIDTH  last quotient
Remainder_out  output  WIDTH  last remainder
Busy  output  1  high while in CALC
Done  output  1  high while in DONE
Div_zero  output  1  last start had divisor 0
Ahex0..Ahex3  output  7 each  HexDriver of SW nibbles 0..3
Bhex0..Bhex3  output  7 each  HexDriver of reg_out nibbles 0..3

Behaviour:
- Reset low (async): state IDLE; reg_out, Quotient_out, Remainder_out, divisor reg, bit counter = 0; Busy, Done, Div_zero = 0; synchronizers cleared (buttons read as released).
- Load_B and Run each pass through a 2-flop synchronizer, then invert; ld and go denote the synchronized active-high levels; every latency below counts from the edge where ld/go is high.
- FSM: IDLE, CALC, DONE.
- IDLE: ld=1 -> reg_out <= SW. Else go=1 -> capture divisor <= SW, working R <= 0, Q <= reg_out, counter <= 0; divisor == 0 -> DONE directly, otherwise -> CALC. ld has priority over go in the same cycle; a held Run starts on the following cycle using the newly loaded dividend.
- CALC (exactly WIDTH cycles): T = {R, Q[WIDTH-1]} (WIDTH+1 bits); Q <= Q << 1; if T >= divisor then R <= T - divisor and Q[0] <= 1, else R <= T[WIDTH-1:0] and Q[0] <= 0. Compare/subtract at WIDTH+1 bits; no overflow possible. Counter increments each cycle; at counter == WIDTH-1 -> DONE.
- DONE entry (registered): Quotient_out <= Q, Remainder_out <= R, reg_out <= Q, Div_zero <= 0.
- Divide by zero: Quotient_out <= all ones, Remainder_out <= dividend, reg_out unchanged, Div_zero <= 1.
- Latency: go sampled in IDLE -> Busy high next cycle for WIDTH cycles -> Done high on cycle WIDTH+1 after go. Divide by zero: Done on the cycle after go.
- DONE: hold all outputs; stay while go=1; go=0 -> IDLE. One press gives exactly one division.
- ld ignored in CALC and DONE. SW changes during CALC have no effect (divisor captured).
- Results and Div_zero persist through IDLE until the next completed start or reset.
- Reset mid-CALC: immediate abort to the reset state; no partial result is visible.
- Hex outputs are combinational from SW and reg_out.

Test Plan:
- Reset, SW=0x0064, press/release Load_B, SW=0x0007, press Run -> Busy for 16 cycles, then Done; Quotient_out=0x000E, Remainder_out=0x0002, reg_out=0x000E.
- Dividend 0xFFFF, divisor 0x0001 -> Quotient 0xFFFF, Remainder 0x0000; dividend 0x0005, divisor 0x0009 -> Quotient 0x0000, Remainder 0x0005.
- Chain: load 0x03E8, divisor 0x000A, Run -> reg_out=0x0064; release, press Run again -> reg_out=0x000A, Remainder 0x0000.
- Dividend 0x1234, divisor 0x0000, Run -> Done the cycle after go, Div_zero=1, Quotient 0xFFFF, Remainder 0x1234, reg_out=0x1234, Busy never high.
- Hold Run for 50 cycles -> exactly one division. Press Load_B during CALC and change SW -> result unaffected, reg_out = quotient.
- Assert Reset at CALC cycle 8 -> all outputs 0 immediately, state IDLE; a fresh load + Run afterwards gives the correct result.
